regfile_scheduler: RTL and testbench

REGFILE_SCHEDULER -- requirements
Module: regfile_scheduler

---
 rtl/regfile_scheduler_pkg.sv | 19 +
 rtl/regfile_scheduler_if.sv | 39 +++
 rtl/wb_queue.sv | 69 ++++++
 rtl/regfile_scheduler.sv | 126 ++++++++++++
 tb/tb_regfile_scheduler.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_scheduler_pkg.sv
// Shared types and widths for the register-file read/writeback scheduler.
package regfile_scheduler_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;

  // Last operation issued to the register file.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } op_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_scheduler_if.sv
// Decode/writeback/regfile signal bundle seen by the scheduler.
interface regfile_scheduler_if
  import regfile_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic                    rd_req;
  logic [REG_ADDR_W-1:0]   rd_addr1;
  logic [REG_ADDR_W-1:0]   rd_addr2;
  logic                    rd_grant;
  logic                    rd_data_valid;

  logic                    wb_valid;
  logic [REG_ADDR_W-1:0]   wb_addr;
  logic [REG_DATA_W-1:0]   wb_data;
  logic                    wb_ready;

  logic                    rf_read_enable;
  logic                    rf_write_enable;
  logic [REG_ADDR_W-1:0]   rf_read_addr1;
  logic [REG_ADDR_W-1:0]   rf_read_addr2;
  logic [REG_ADDR_W-1:0]   rf_write_addr;
  logic [REG_DATA_W-1:0]   rf_write_data;
  logic [$clog2(DEPTH):0]  queue_count;

  modport master (
    output rd_req, rd_addr1, rd_addr2, wb_valid, wb_addr, wb_data,
    input  rd_grant, rd_data_valid, wb_ready, rf_read_enable, rf_write_enable,
           rf_read_addr1, rf_read_addr2, rf_write_addr, rf_write_data, queue_count
  );

  modport slave (
    input  rd_req, rd_addr1, rd_addr2, wb_valid, wb_addr, wb_data,
    output rd_grant, rd_data_valid, wb_ready, rf_read_enable, rf_write_enable,
           rf_read_addr1, rf_read_addr2, rf_write_addr, rf_write_data, queue_count
  );

endinterface

// File: rtl/wb_queue.sv
// Writeback FIFO: entry storage, wrap-around pointers, occupancy and
// per-entry address compare against the pending read operands.
module wb_queue
  import regfile_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  wb_entry_t              i_push_entry,
  input  logic [REG_ADDR_W-1:0]  i_cmp_addr1,
  input  logic [REG_ADDR_W-1:0]  i_cmp_addr2,
  output wb_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DEPTH-1:0]       o_match
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t          r_mem [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;

  // NOTE: the storage array has no reset; r_valid qualifies every use of it,
  // so clearing the valid bits is enough to empty the queue.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (i_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = r_valid[i] &&
                   ((r_mem[i].addr == i_cmp_addr1) || (r_mem[i].addr == i_cmp_addr2));
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/regfile_scheduler.sv
// Arbitrates the single regfile port between decode reads and queued
// writebacks, withholding reads that would bypass a pending write (RAW).
module regfile_scheduler
  import regfile_scheduler_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_READ_STREAK = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scheduler_if.slave   bus
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int STREAK_W = $clog2(MAX_READ_STREAK + 1);
  localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_READ_STREAK);

  op_state_e               r_state;
  op_state_e               w_next_state;
  logic [STREAK_W-1:0]     r_streak;
  logic [STREAK_W-1:0]     w_next_streak;
  logic                    r_rd_data_valid;
  logic [REG_ADDR_W-1:0]   r_rd_addr1;
  logic [REG_ADDR_W-1:0]   r_rd_addr2;
  logic [REG_ADDR_W-1:0]   r_wr_addr;
  logic [REG_DATA_W-1:0]   r_wr_data;

  wb_entry_t               w_push_entry;
  wb_entry_t               w_head;
  logic [CNT_W-1:0]        w_count;
  logic [DEPTH-1:0]        w_match;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_push_hit;
  logic                    w_hazard;

  assign w_full       = (w_count == FULL_CNT);
  assign w_empty      = (w_count == '0);
  assign w_push       = bus.wb_valid && !w_full;
  assign w_pop        = (w_next_state == OP_WRITE);
  assign w_push_entry = '{addr: bus.wb_addr, data: bus.wb_data};

  // A push landing this cycle is not yet in the queue but still blocks the read.
  assign w_push_hit = w_push &&
                      ((bus.wb_addr == bus.rd_addr1) || (bus.wb_addr == bus.rd_addr2));
  assign w_hazard   = bus.rd_req && ((|w_match) || w_push_hit);

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_wb_queue (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_push_entry (w_push_entry),
    .i_cmp_addr1  (bus.rd_addr1),
    .i_cmp_addr2  (bus.rd_addr2),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_match      (w_match)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = OP_IDLE;
    if (w_full) begin
      w_next_state = OP_WRITE;
    end else if (!w_empty && (r_streak == STREAK_MAX)) begin
      w_next_state = OP_WRITE;
    end else if (w_hazard) begin
      w_next_state = w_empty ? OP_IDLE : OP_WRITE;
    end else if (bus.rd_req) begin
      w_next_state = OP_READ;
    end else if (!w_empty) begin
      w_next_state = OP_WRITE;
    end
  end

  // Streak only counts reads that kept a non-empty queue waiting.
  always_comb begin
    w_next_streak = r_streak;
    if (w_pop || w_empty) begin
      w_next_streak = '0;
    end else if ((w_next_state == OP_READ) && (r_streak != STREAK_MAX)) begin
      w_next_streak = r_streak + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= OP_IDLE;
      r_streak        <= '0;
      r_rd_data_valid <= 1'b0;
      r_rd_addr1      <= '0;
      r_rd_addr2      <= '0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
    end else begin
      r_state         <= w_next_state;
      r_streak        <= w_next_streak;
      r_rd_data_valid <= (r_state == OP_READ);
      r_rd_addr1      <= (w_next_state == OP_READ) ? bus.rd_addr1 : '0;
      r_rd_addr2      <= (w_next_state == OP_READ) ? bus.rd_addr2 : '0;
      r_wr_addr       <= w_pop ? w_head.addr : '0;
      r_wr_data       <= w_pop ? w_head.data : '0;
    end
  end

  assign bus.rf_read_enable  = (r_state == OP_READ);
  assign bus.rf_write_enable = (r_state == OP_WRITE);
  assign bus.rd_grant        = (r_state == OP_READ);
  assign bus.rd_data_valid   = r_rd_data_valid;
  assign bus.rf_read_addr1   = r_rd_addr1;
  assign bus.rf_read_addr2   = r_rd_addr2;
  assign bus.rf_write_addr   = r_wr_addr;
  assign bus.rf_write_data   = r_wr_data;
  assign bus.wb_ready        = !w_full;
  assign bus.queue_count     = w_count;

endmodule

// File: tb/tb_regfile_scheduler.sv
// Randomised and directed bench for regfile_scheduler against a queue-based
// reference model of the issue rules, plus a small regfile for data checks.
module tb_regfile_scheduler;
  import regfile_scheduler_pkg::*;

  localparam int DEPTH  = 4;
  localparam int MAX_RS = 3;
  localparam logic [1:0] OPI = 2'b00;
  localparam logic [1:0] OPR = 2'b10;
  localparam logic [1:0] OPW = 2'b01;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  regfile_scheduler_if #(.DEPTH(DEPTH)) bus();

  regfile_scheduler #(
    .DEPTH           (DEPTH),
    .MAX_READ_STREAK (MAX_RS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT strobes; read data appears one cycle later.
  logic [15:0] h_rf [8];
  logic [15:0] h_rd1, h_rd2;
  always @(posedge clk) begin
    if (bus.rf_write_enable) h_rf[bus.rf_write_addr] <= bus.rf_write_data;
    if (bus.rf_read_enable) begin
      h_rd1 <= h_rf[bus.rf_read_addr1];
      h_rd2 <= h_rf[bus.rf_read_addr2];
    end
  end

  // Reference model state.
  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } ment_t;
  ment_t       mq[$];
  int          m_streak = 0;
  bit          m_prev_grant = 0;
  bit          m_granted = 0;
  bit          m_pushed = 0;
  logic [15:0] arch [8];
  bit          known [8];
  logic [15:0] pend1, pend2;
  bit          pk1 = 0, pk2 = 0;

  logic [1:0]  e_op;
  logic        e_dv, e_ready;
  logic [2:0]  e_ra1, e_ra2, e_wa;
  logic [15:0] e_wd, e_d1, e_d2;
  int          e_cnt;
  bit          e_chk1, e_chk2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_streak     = 0;
    m_prev_grant = 0;
    m_granted    = 0;
    m_pushed     = 0;
    pk1          = 0;
    pk2          = 0;
  endtask

  // Predicts what the DUT shows after the next rising edge, from the rules.
  task automatic model_step();
    int    cnt;
    bit    push, haz;
    ment_t h;
    cnt  = mq.size();
    push = bus.wb_valid && (cnt < DEPTH);
    haz  = 0;
    if (bus.rd_req) begin
      foreach (mq[i])
        if (mq[i].addr == bus.rd_addr1 || mq[i].addr == bus.rd_addr2) haz = 1;
      if (push && (bus.wb_addr == bus.rd_addr1 || bus.wb_addr == bus.rd_addr2)) haz = 1;
    end
    if (cnt == DEPTH)                    e_op = OPW;
    else if (cnt > 0 && m_streak == MAX_RS) e_op = OPW;
    else if (haz)                        e_op = (cnt > 0) ? OPW : OPI;
    else if (bus.rd_req)                 e_op = OPR;
    else if (cnt > 0)                    e_op = OPW;
    else                                 e_op = OPI;

    e_dv   = m_prev_grant;
    e_chk1 = e_dv && pk1;
    e_chk2 = e_dv && pk2;
    e_d1   = pend1;
    e_d2   = pend2;
    e_ra1 = '0; e_ra2 = '0; e_wa = '0; e_wd = '0;
    if (e_op == OPR) begin
      e_ra1 = bus.rd_addr1;
      e_ra2 = bus.rd_addr2;
      pend1 = arch[bus.rd_addr1]; pk1 = known[bus.rd_addr1];
      pend2 = arch[bus.rd_addr2]; pk2 = known[bus.rd_addr2];
    end
    if (e_op == OPW) begin
      h = mq.pop_front();
      e_wa = h.addr;
      e_wd = h.data;
      arch[h.addr]  = h.data;
      known[h.addr] = 1;
    end
    if (push) mq.push_back('{addr: bus.wb_addr, data: bus.wb_data});
    if (e_op == OPW || cnt == 0) m_streak = 0;
    else if (e_op == OPR && m_streak < MAX_RS) m_streak++;
    m_prev_grant = (e_op == OPR);
    m_granted    = (e_op == OPR);
    m_pushed     = push;
    e_cnt   = mq.size();
    e_ready = (e_cnt < DEPTH);
  endtask

  task automatic compare_all();
    check("op", 32'({bus.rf_read_enable, bus.rf_write_enable}), 32'(e_op));
    check("excl", 32'(bus.rf_read_enable & bus.rf_write_enable), 32'(0));
    check("grant", 32'(bus.rd_grant), 32'(e_op == OPR));
    check("dvalid", 32'(bus.rd_data_valid), 32'(e_dv));
    check("raddr", 32'({bus.rf_read_addr1, bus.rf_read_addr2}), 32'({e_ra1, e_ra2}));
    check("wentry", 32'({bus.rf_write_addr, bus.rf_write_data}), 32'({e_wa, e_wd}));
    check("count", 32'(bus.queue_count), 32'(e_cnt));
    check("ready", 32'(bus.wb_ready), 32'(e_ready));
    if (e_chk1) check("rdata1", 32'(h_rd1), 32'(e_d1));
    if (e_chk2) check("rdata2", 32'(h_rd2), 32'(e_d2));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive_rd(input bit req, input int a1, input int a2);
    bus.rd_req   = req;
    bus.rd_addr1 = 3'(a1);
    bus.rd_addr2 = 3'(a2);
  endtask

  task automatic drive_wb(input bit v, input int a, input int d);
    bus.wb_valid = v;
    bus.wb_addr  = 3'(a);
    bus.wb_data  = 16'(d);
  endtask

  task automatic drain();
    drive_rd(0, 0, 0);
    drive_wb(0, 0, 0);
    repeat (DEPTH + 2) step();
  endtask

  logic [1:0] t2_exp [5];
  logic [2:0] got_wa [$];
  logic [2:0] t3_order [5];
  bit         rq_on, wv_on;

  initial begin
    for (int i = 0; i < 8; i++) known[i] = 0;
    drive_rd(0, 0, 0);
    drive_wb(0, 0, 0);

    // Reset state.
    #3;
    check("rst_count", 32'(bus.queue_count), 32'(0));
    check("rst_strobes", 32'({bus.rf_read_enable, bus.rf_write_enable, bus.rd_grant, bus.rd_data_valid}), 32'(0));
    check("rst_ready", 32'(bus.wb_ready), 32'(1));
    @(posedge clk); #1;
    reset = 1'b1;

    // Queued write to R3 goes first, then the read sees its value.
    drive_wb(1, 3, 16'h00AA);
    step();
    drive_wb(0, 0, 0);
    drive_rd(1, 3, 5);
    step();
    check("t1_write_first", 32'({bus.rf_write_enable, bus.rf_write_addr}), 32'({1'b1, 3'd3}));
    step();
    check("t1_read_next", 32'(bus.rf_read_enable), 32'(1));
    drive_rd(0, 0, 0);
    step();
    check("t1_dvalid", 32'(bus.rd_data_valid), 32'(1));
    check("t1_data1", 32'(h_rd1), 32'(16'h00AA));
    drain();

    // Read streak forces the R7 write after MAX_RS reads.
    t2_exp = '{OPR, OPR, OPR, OPW, OPR};
    drive_rd(1, 1, 2);
    drive_wb(1, 7, 16'h1234);
    step();
    drive_wb(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_seq", 32'({bus.rf_read_enable, bus.rf_write_enable}), 32'(t2_exp[i]));
    end
    drain();

    // Fill to DEPTH behind reads; fifth push held; drain order.
    t3_order = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    drive_rd(1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive_wb(1, 2 + i, 16'h0100 + i);
      step();
    end
    check("t3_full_count", 32'(bus.queue_count), 32'(4));
    check("t3_not_ready", 32'(bus.wb_ready), 32'(0));
    drive_rd(0, 0, 0);
    drive_wb(1, 6, 16'h0106);
    got_wa.delete();
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) check("t3_fifth_held", 32'(bus.queue_count), 32'(3));
      if (m_pushed) drive_wb(0, 0, 0);
      if (bus.rf_write_enable) got_wa.push_back(bus.rf_write_addr);
    end
    check("t3_drain_len", 32'(got_wa.size()), 32'(5));
    for (int i = 0; i < 5 && i < got_wa.size(); i++)
      check("t3_drain_order", 32'(got_wa[i]), 32'(t3_order[i]));
    drain();

    // Push and pop together at count 2; pointers keep wrapping.
    drive_rd(1, 1, 2);
    drive_wb(1, 4, 16'h0044);
    step();
    drive_wb(1, 5, 16'h0055);
    step();
    drive_rd(0, 0, 0);
    drive_wb(1, 6, 16'h0066);
    step();
    check("t4_pushpop_count", 32'(bus.queue_count), 32'(2));
    check("t4_pushpop_write", 32'({bus.rf_write_enable, bus.rf_write_addr}), 32'({1'b1, 3'd4}));
    for (int i = 0; i < 3; i++) begin
      drive_wb(1, 7 - i, 16'h0070 + i);
      step();
    end
    drain();

    // Asynchronous reset with three writes queued.
    drive_rd(1, 1, 2);
    for (int i = 0; i < 3; i++) begin
      drive_wb(1, 3 + i, 16'h0300 + i);
      step();
    end
    check("t5_pre_count", 32'(bus.queue_count), 32'(3));
    drive_rd(0, 0, 0);
    drive_wb(0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("t5_async_count", 32'(bus.queue_count), 32'(0));
    check("t5_async_strobes", 32'({bus.rf_read_enable, bus.rf_write_enable, bus.rd_grant, bus.rd_data_valid}), 32'(0));
    check("t5_async_ready", 32'(bus.wb_ready), 32'(1));
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    check("t5_no_write", 32'(bus.rf_write_enable), 32'(0));
    step();

    // Random traffic with hazards; requests and pushes held until taken.
    rq_on = 0;
    wv_on = 0;
    for (int c = 0; c < 600; c++) begin
      if (!rq_on && $urandom_range(0, 99) < 55) begin
        rq_on = 1;
        drive_rd(1, $urandom_range(0, 7), $urandom_range(0, 7));
      end
      if (!wv_on && $urandom_range(0, 99) < 45) begin
        wv_on = 1;
        drive_wb(1, $urandom_range(0, 7), $urandom_range(0, 16'hFFFF));
      end
      step();
      if (m_granted) begin rq_on = 0; bus.rd_req = 1'b0; end
      if (m_pushed)  begin wv_on = 0; bus.wb_valid = 1'b0; end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
